// File: rtl/chocorrol_pkg.sv
// chocorrol_pkg: opcodes and instruction field positions for the chocorrol pipeline
// Instruction layout, MSB first: {we, src1, src2, dst, rsvd, op[2:0]}
package chocorrol_pkg;
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b101;
   localparam logic [2:0] OP_SLT = 3'b111;
   localparam int DST_LO = 4;
   localparam int RSVD_POS = 3;
   function automatic int instr_w(input int aw);
      return 3 * aw + 5;
   endfunction
   function automatic int we_pos(input int aw);
      return 3 * aw + 4;
   endfunction
   function automatic int src1_lo(input int aw);
      return 2 * aw + 4;
   endfunction
   function automatic int src2_lo(input int aw);
      return aw + 4;
   endfunction
endpackage

// File: rtl/chocorrol_alu.sv
// chocorrol_alu: combinational ALU, op + two operands -> result
// Ports: op (3-bit opcode), a/b (DATA_W operands), y (DATA_W result; unused opcodes give 0)
module chocorrol_alu import chocorrol_pkg::*; #(
   parameter int DATA_W = 32
) (
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] y
);
   always_comb begin
      y = op == OP_AND ? a & b :
          op == OP_OR  ? a | b :
          op == OP_ADD ? a + b :
          op == OP_SUB ? a - b :
          op == OP_SLT ? DATA_W'($signed(a) < $signed(b)) : '0;
   end
endmodule

// File: rtl/chocorrol_pipe.sv
// chocorrol_pipe: 3-stage decode / A-read / ALU / B-write pipeline with valid-ready input
// Ports: clk, rst (sync, active-high); a_wr_en/a_wr_addr/a_wr_data load memory A;
//   in_valid/in_ready/instr instruction handshake; res_valid/res_data/res_addr/res_is_wr result strobe.
// Macro CHOCORROL_BYPASS_EN: forward the S2 result into a hazarding S1 read instead of stalling.
module chocorrol_pipe import chocorrol_pkg::*; #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       a_wr_en,
   input  logic [ADDR_W-1:0]          a_wr_addr,
   input  logic [DATA_W-1:0]          a_wr_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [instr_w(ADDR_W)-1:0] instr,
   output logic                       res_valid,
   output logic [DATA_W-1:0]          res_data,
   output logic [ADDR_W-1:0]          res_addr,
   output logic                       res_is_wr
);
   logic [DATA_W-1:0] a_mem [2**ADDR_W];
   logic [DATA_W-1:0] b_mem [2**ADDR_W];
   logic              s1_valid, s1_we;
   logic [ADDR_W-1:0] s1_src1, s1_src2, s1_dst;
   logic [2:0]        s1_op;
   logic [DATA_W-1:0] op1, op2, alu_y, b_rd, s1_res;
   logic              hazard, stall;
   logic              rsvd_unused;
   assign rsvd_unused = instr[RSVD_POS];
   chocorrol_alu #(.DATA_W(DATA_W)) u_alu (.op(s1_op), .a(op1), .b(op2), .y(alu_y));
   // S2 (the res_* registers) writes B on the edge that retires it, so a read in S1
   // of the same address would see the stale word without bypass or interlock.
   always_comb begin
      op1 = a_mem[s1_src1];
      op2 = a_mem[s1_src2];
      hazard = s1_valid && !s1_we && res_valid && res_is_wr && res_addr == s1_src1;
`ifdef CHOCORROL_BYPASS_EN
      stall = 1'b0;
      b_rd = hazard ? res_data : b_mem[s1_src1];
`else
      stall = hazard;
      b_rd = b_mem[s1_src1];
`endif
      in_ready = !stall;
      s1_res = s1_we ? alu_y : b_rd;
   end
   always_ff @(posedge clk) begin
      if (a_wr_en) a_mem[a_wr_addr] <= a_wr_data;
   end
   always_ff @(posedge clk) begin
      if (!rst && res_valid && res_is_wr) b_mem[res_addr] <= res_data;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_addr  <= '0;
         res_is_wr <= 1'b0;
      end else begin
         res_valid <= s1_valid && !stall;
         res_data  <= s1_res;
         res_addr  <= s1_we ? s1_dst : s1_src1;
         res_is_wr <= s1_we;
         if (!stall) begin
            s1_valid <= in_valid;
            s1_we    <= instr[we_pos(ADDR_W)];
            s1_src1  <= instr[src1_lo(ADDR_W) +: ADDR_W];
            s1_src2  <= instr[src2_lo(ADDR_W) +: ADDR_W];
            s1_dst   <= instr[DST_LO +: ADDR_W];
            s1_op    <= instr[2:0];
         end
      end
   end
endmodule
